// File: rtl/icache_refill_ctrl_pkg.sv
// Shared fetch-side definitions for the I-cache refill controller.
// Holds the address/block/beat widths, the derived beat and offset
// constants, the refill FSM encoding and a block-alignment helper.
package icache_refill_ctrl_pkg;

  localparam int SIZE_PC     = 32;   // PC / address width
  localparam int CACHE_WIDTH = 256;  // bits per cache block
  localparam int MEM_WIDTH   = 64;   // bits per memory read beat

  // Number of memory beats that make one cache block.
  localparam int BEATS      = CACHE_WIDTH / MEM_WIDTH;
  // Byte-offset bits inside a block; cleared to form the request address.
  localparam int OFF        = $clog2(CACHE_WIDTH / 8);
  // One extra bit so the count can reach BEATS without wrapping.
  localparam int BEAT_CNT_W = $clog2(BEATS) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    COOL  = 3'd4
  } refill_state_t;

  function automatic logic [SIZE_PC-1:0] blockAlign(input logic [SIZE_PC-1:0] addr);
    return {addr[SIZE_PC-1:OFF], {OFF{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Memory-side read bus between the refill controller and the lower
// memory hierarchy.
//   memReq_o     : read request valid (controller -> memory)
//   memReqAddr_o : block-aligned request address (controller -> memory)
//   memReqAck_i  : memory accepted the request (memory -> controller)
//   memRdValid_i : read beat valid (memory -> controller)
//   memRdData_i  : read beat data (memory -> controller)
//
// Handshake: a request is transferred in the cycle where memReq_o and
// memReqAck_i are both high; memReq_o and memReqAddr_o stay stable until
// then. Read beats have no backpressure: every cycle with memRdValid_i high
// delivers one beat, in order, beat 0 first.
interface icache_refill_ctrl_if;
  import icache_refill_ctrl_pkg::*;

  logic                 memReq_o;
  logic [SIZE_PC-1:0]   memReqAddr_o;
  logic                 memReqAck_i;
  logic                 memRdValid_i;
  logic [MEM_WIDTH-1:0] memRdData_i;

  // Controller side.
  modport master (
    output memReq_o,
    output memReqAddr_o,
    input  memReqAck_i,
    input  memRdValid_i,
    input  memRdData_i
  );

  // Memory side.
  modport slave (
    input  memReq_o,
    input  memReqAddr_o,
    output memReqAck_i,
    output memRdValid_i,
    output memRdData_i
  );

endinterface

// File: rtl/icache_refill_ctrl_assembler.sv
// icache_refill_assembler: collects memory read beats into one cache block.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the beat count for a new refill
//   beatValid  : accept beatData into the next slice
//   beatData   : one memory beat
//   block      : assembled block, beat 0 in the LSBs
//   beatCnt    : beats captured so far in this refill
//   full       : all BEATS beats captured
module icache_refill_assembler
  import icache_refill_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  beatValid,
  input  logic [MEM_WIDTH-1:0]  beatData,
  output logic [CACHE_WIDTH-1:0] block,
  output logic [BEAT_CNT_W-1:0] beatCnt,
  output logic                  full
);

  logic [CACHE_WIDTH-1:0]  blockBuf;
  logic [BEAT_CNT_W-1:0]   cnt;
  logic [BEAT_CNT_W-2:0]   beatIdx;

  assign beatIdx = cnt[BEAT_CNT_W-2:0];
  assign full    = (cnt == BEAT_CNT_W'(BEATS));
  assign block   = blockBuf;
  assign beatCnt = cnt;

  // Once full, further beats are dropped so the counter never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      blockBuf <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (beatValid && !full) begin
      blockBuf[beatIdx*MEM_WIDTH +: MEM_WIDTH] <= beatData;
      cnt <= cnt + BEAT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: L1 instruction-cache refill controller.
// On a fetch miss it issues one block-aligned read, gathers BEATS beats
// into a block and writes it back into the I-cache for one cycle.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   miss_i        : fetch miss request
//   missAddr_i    : miss PC
//   flush_i       : cancels a request not yet accepted by memory
//   memBus        : memory read bus (master side)
//   wrEnable_o    : one-cycle cache write strobe
//   wrAddr_o      : block address of the write
//   instBlock_o   : assembled block
//   busy_o        : a refill is in progress (state not IDLE)
//   refillCount_o : completed refills, saturating
//   dbgState_o    : current FSM state
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_i,
  input  logic [SIZE_PC-1:0]     missAddr_i,
  input  logic                   flush_i,
  icache_refill_ctrl_if.master   memBus,
  output logic                   wrEnable_o,
  output logic [SIZE_PC-1:0]     wrAddr_o,
  output logic [CACHE_WIDTH-1:0] instBlock_o,
  output logic                   busy_o,
  output logic [CNT_WIDTH-1:0]   refillCount_o,
  output refill_state_t          dbgState_o
);

  refill_state_t          state;
  logic [SIZE_PC-1:0]     blkAddr;
  logic                   memReq;
  logic                   wrEnable;
  logic [CNT_WIDTH-1:0]   refillCount;

  logic                   startRefill;
  logic                   beatValid;
  logic                   lastBeat;
  logic [BEAT_CNT_W-1:0]  beatCnt;
  logic                   full;
  logic [CACHE_WIDTH-1:0] block;

  // A flush in the miss cycle suppresses the refill entirely.
  assign startRefill = (state == IDLE) && miss_i && !flush_i;
  // Beats outside DATA are dropped before they reach the buffer.
  assign beatValid   = (state == DATA) && memBus.memRdValid_i;
  assign lastBeat    = beatValid && !full && (beatCnt == BEAT_CNT_W'(BEATS - 1));

  icache_refill_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (startRefill),
    .beatValid (beatValid),
    .beatData  (memBus.memRdData_i),
    .block     (block),
    .beatCnt   (beatCnt),
    .full      (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      blkAddr     <= '0;
      memReq      <= 1'b0;
      wrEnable    <= 1'b0;
      refillCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startRefill) begin
            blkAddr <= blockAlign(missAddr_i);
            memReq  <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // An accepted request must complete, so ack wins over flush.
          if (memBus.memReqAck_i) begin
            memReq <= 1'b0;
            state  <= DATA;
          end else if (flush_i) begin
            memReq <= 1'b0;
            state  <= IDLE;
          end
        end
        DATA: begin
          if (lastBeat) begin
            wrEnable <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          wrEnable <= 1'b0;
          if (refillCount != '1) begin
            refillCount <= refillCount + CNT_WIDTH'(1);
          end
          state <= COOL;
        end
        COOL: begin
          // Turnaround cycle: a miss still asserted for the block just
          // written is not sampled here.
          state <= IDLE;
        end
        default: begin
          memReq   <= 1'b0;
          wrEnable <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign memBus.memReq_o     = memReq;
  assign memBus.memReqAddr_o = blkAddr;
  assign wrEnable_o          = wrEnable;
  assign wrAddr_o            = blkAddr;
  assign instBlock_o         = block;
  assign busy_o              = (state != IDLE);
  assign refillCount_o       = refillCount;
  assign dbgState_o          = state;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                   miss_i = 1'b0;
  logic [SIZE_PC-1:0]     missAddr_i = '0;
  logic                   flush_i = 1'b0;
  logic                   wrEnable_o;
  logic [SIZE_PC-1:0]     wrAddr_o;
  logic [CACHE_WIDTH-1:0] instBlock_o;
  logic                   busy_o;
  logic [15:0]            refillCount_o;
  refill_state_t          dbgState_o;

  icache_refill_ctrl_if bus ();

  icache_refill_ctrl #(.CNT_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .miss_i        (miss_i),
    .missAddr_i    (missAddr_i),
    .flush_i       (flush_i),
    .memBus        (bus),
    .wrEnable_o    (wrEnable_o),
    .wrAddr_o      (wrAddr_o),
    .instBlock_o   (instBlock_o),
    .busy_o        (busy_o),
    .refillCount_o (refillCount_o),
    .dbgState_o    (dbgState_o)
  );

  // Narrow-counter copy driven by identical stimulus, used to reach
  // counter saturation in a few refills.
  icache_refill_ctrl_if sbus ();
  assign sbus.memReqAck_i  = bus.memReqAck_i;
  assign sbus.memRdValid_i = bus.memRdValid_i;
  assign sbus.memRdData_i  = bus.memRdData_i;

  logic                   s_wrEnable;
  logic [SIZE_PC-1:0]     s_wrAddr;
  logic [CACHE_WIDTH-1:0] s_instBlock;
  logic                   s_busy;
  logic [2:0]             s_refillCount;
  refill_state_t          s_dbgState;

  icache_refill_ctrl #(.CNT_WIDTH(3)) dut_small (
    .clk           (clk),
    .reset         (reset),
    .miss_i        (miss_i),
    .missAddr_i    (missAddr_i),
    .flush_i       (flush_i),
    .memBus        (sbus),
    .wrEnable_o    (s_wrEnable),
    .wrAddr_o      (s_wrAddr),
    .instBlock_o   (s_instBlock),
    .busy_o        (s_busy),
    .refillCount_o (s_refillCount),
    .dbgState_o    (s_dbgState)
  );

  // ---------------- scoreboard ----------------
  int compared = 0;
  int mismatched = 0;
  int wrPulses = 0;
  logic [255:0] exp_q[$];

  always @(posedge clk) if (wrEnable_o) wrPulses <= wrPulses + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d);
    bus.memRdValid_i = 1'b1;
    bus.memRdData_i  = d;
    step();
    bus.memRdValid_i = 1'b0;
    bus.memRdData_i  = '0;
  endtask

  typedef struct {
    logic [31:0]      addr;
    int               ackDelay;
    int               gap;
    bit               flushAtAck;
    bit               flushInData;
    logic [3:0][63:0] beats;
    logic [31:0]      expAddr;
    logic [255:0]     expBlock;
    int               expCount;
  } vec_t;

  vec_t vecs[3];

  task automatic run_vec(input vec_t v, input string tag);
    int p0;
    p0 = wrPulses;
    miss_i = 1'b1;
    missAddr_i = v.addr;
    step();
    miss_i = 1'b0;
    missAddr_i = 32'hDEAD_BEEF;  // late change must not affect the refill
    check({tag, "_req_valid"}, 256'(bus.memReq_o), 256'(1));
    check({tag, "_req_addr"}, 256'(bus.memReqAddr_o), 256'(v.expAddr));
    for (int i = 0; i < v.ackDelay; i++) begin
      step();
      check({tag, "_req_hold"}, 256'({bus.memReq_o, bus.memReqAddr_o}), 256'({1'b1, v.expAddr}));
    end
    bus.memReqAck_i = 1'b1;
    flush_i = v.flushAtAck;
    step();
    bus.memReqAck_i = 1'b0;
    flush_i = 1'b0;
    check({tag, "_ack_state"}, 256'(dbgState_o), 256'(DATA));
    check({tag, "_req_drop"}, 256'(bus.memReq_o), 256'(0));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < v.gap; g++) begin
        flush_i = v.flushInData;
        step();
        flush_i = 1'b0;
      end
      send_beat(v.beats[b]);
      if (b < 3) check({tag, "_no_early_write"}, 256'(wrEnable_o), 256'(0));
    end
    exp_q.push_back(v.expBlock);
    check({tag, "_wr_en"}, 256'(wrEnable_o), 256'(1));
    check({tag, "_wr_addr"}, 256'(wrAddr_o), 256'(v.expAddr));
    check({tag, "_block"}, instBlock_o, exp_q.pop_front());
    step();
    check({tag, "_wr_pulse_end"}, 256'(wrEnable_o), 256'(0));
    check({tag, "_cool"}, 256'(dbgState_o), 256'(COOL));
    check({tag, "_count"}, 256'(refillCount_o), 256'(v.expCount));
    check({tag, "_pulses"}, 256'(wrPulses - p0), 256'(1));
    step();
    check({tag, "_idle"}, 256'(busy_o), 256'(0));
  endtask

  // Zero-wait refill with beats derived from the address; used for volume.
  task automatic quick_refill(input logic [31:0] addr);
    miss_i = 1'b1;
    missAddr_i = addr;
    step();
    miss_i = 1'b0;
    bus.memReqAck_i = 1'b1;
    step();
    bus.memReqAck_i = 1'b0;
    for (int b = 0; b < 4; b++) send_beat({addr, 32'(b)});
    step();
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.memReqAck_i  = 1'b0;
    bus.memRdValid_i = 1'b0;
    bus.memRdData_i  = '0;

    vecs[0] = '{addr: 32'h0000_1234, ackDelay: 0, gap: 0, flushAtAck: 1'b0, flushInData: 1'b0,
                beats: {64'h4444444444444444, 64'h3333333333333333,
                        64'h2222222222222222, 64'h1111111111111111},
                expAddr: 32'h0000_1220,
                expBlock: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                expCount: 1};
    vecs[1] = '{addr: 32'h8000_00FF, ackDelay: 5, gap: 2, flushAtAck: 1'b0, flushInData: 1'b1,
                beats: {64'hCAFEF00D00000002, 64'hDEADBEEF00000001,
                        64'hFEDCBA9876543210, 64'h0123456789ABCDEF},
                expAddr: 32'h8000_00E0,
                expBlock: 256'hCAFEF00D00000002_DEADBEEF00000001_FEDCBA9876543210_0123456789ABCDEF,
                expCount: 2};
    vecs[2] = '{addr: 32'hFFFF_FFFF, ackDelay: 1, gap: 0, flushAtAck: 1'b1, flushInData: 1'b0,
                beats: {64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000,
                        64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555},
                expAddr: 32'hFFFF_FFE0,
                expBlock: 256'hFFFFFFFFFFFFFFFF_0000000000000000_AAAAAAAAAAAAAAAA_5555555555555555,
                expCount: 3};

    // Reset values
    step();
    step();
    check("rst_req", 256'(bus.memReq_o), 256'(0));
    check("rst_addr", 256'(bus.memReqAddr_o), 256'(0));
    check("rst_block", instBlock_o, 256'(0));
    check("rst_count", 256'(refillCount_o), 256'(0));
    check("rst_busy", 256'(busy_o), 256'(0));
    reset = 1'b0;
    step();

    // Basic, backpressure + flush ignored in DATA, flush together with ack
    for (int i = 0; i < 3; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush in REQ without ack: cancelled, nothing written
    begin
      int p0;
      p0 = wrPulses;
      miss_i = 1'b1;
      missAddr_i = 32'h0000_3000;
      step();
      miss_i = 1'b0;
      check("flush_req_up", 256'(bus.memReq_o), 256'(1));
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("flush_idle", 256'(dbgState_o), 256'(IDLE));
      check("flush_req_down", 256'(bus.memReq_o), 256'(0));
      step();
      step();
      check("flush_no_write", 256'(wrPulses - p0), 256'(0));
      check("flush_count", 256'(refillCount_o), 256'(3));
    end

    // Flush in the miss cycle blocks entry
    miss_i = 1'b1;
    flush_i = 1'b1;
    step();
    miss_i = 1'b0;
    flush_i = 1'b0;
    check("flush_at_miss", 256'(busy_o), 256'(0));

    // Spurious read beats in IDLE
    for (int i = 0; i < 3; i++) begin
      send_beat(64'h9999_0000_0000_0000 | 64'(i));
      check("spurious_busy", 256'(busy_o), 256'(0));
    end
    check("spurious_block", instBlock_o, vecs[2].expBlock);

    // Stale miss held through WRITE and COOL: re-request only at m+4
    miss_i = 1'b1;
    missAddr_i = 32'h0000_4044;
    step();
    check("stale_req", 256'(bus.memReq_o), 256'(1));
    bus.memReqAck_i = 1'b1;
    step();
    bus.memReqAck_i = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(64'h7700 + 64'(b));
    check("stale_write", 256'(wrEnable_o), 256'(1));
    step();
    check("stale_m2", 256'(bus.memReq_o), 256'(0));
    step();
    check("stale_m3", 256'(bus.memReq_o), 256'(0));
    step();
    check("stale_m4", 256'(bus.memReq_o), 256'(1));
    check("stale_m4_addr", 256'(bus.memReqAddr_o), 256'(32'h0000_4040));
    miss_i = 1'b0;
    bus.memReqAck_i = 1'b1;
    step();
    bus.memReqAck_i = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(64'h8800 + 64'(b));
    step();
    check("stale_count", 256'(refillCount_o), 256'(5));
    step();

    // Reset mid-DATA
    miss_i = 1'b1;
    missAddr_i = 32'h0000_2008;
    step();
    miss_i = 1'b0;
    bus.memReqAck_i = 1'b1;
    step();
    bus.memReqAck_i = 1'b0;
    send_beat(64'hBBBB_BBBB_BBBB_BBBB);
    send_beat(64'hCCCC_CCCC_CCCC_CCCC);
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", 256'(dbgState_o), 256'(IDLE));
    check("arst_busy", 256'(busy_o), 256'(0));
    check("arst_block", instBlock_o, 256'(0));
    check("arst_addr", 256'(bus.memReqAddr_o), 256'(0));
    check("arst_count", 256'(refillCount_o), 256'(0));
    step();
    reset = 1'b0;
    step();
    run_vec(vecs[0], "post_rst");

    // Saturation: narrow copy stops at all-ones, wide copy keeps counting
    for (int k = 0; k < 8; k++) quick_refill(32'h0001_0000 + 32'(k * 32));
    check("sat_small", 256'(s_refillCount), 256'(3'h7));
    check("sat_wide", 256'(refillCount_o), 256'(9));
    check("sat_last_block", instBlock_o,
          256'h000100E0_00000003_000100E0_00000002_000100E0_00000001_000100E0_00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
